// File: rtl/wb_commit_if.sv
// Writeback-side signal bundle: MEM/WB register outputs into the commit stage,
// plus the commit-trace valid/ready read port.
interface wb_commit_if;
  logic        wb_valid;
  logic        wb_adv;
  logic [31:0] wb_pc;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic [31:0] wb_except_type;

  // trace_valid/trace_ready: an entry transfers on any rising edge where both
  // are 1; head fields stay stable while trace_valid=1 and no transfer occurs.
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [4:0]  trace_wd;
  logic [31:0] trace_wdata;
  logic        trace_we;

  modport master (
    output wb_valid, wb_adv, wb_pc, wb_wd, wb_wreg, wb_wdata,
           wb_whilo, wb_hi, wb_lo, wb_except_type, trace_ready,
    input  trace_valid, trace_pc, trace_wd, trace_wdata, trace_we
  );

  modport slave (
    input  wb_valid, wb_adv, wb_pc, wb_wd, wb_wreg, wb_wdata,
           wb_whilo, wb_hi, wb_lo, wb_except_type, trace_ready,
    output trace_valid, trace_pc, trace_wd, trace_wdata, trace_we
  );
endinterface

// File: rtl/wb_commit.sv
// Writeback/commit stage: GPR write port, bypassed HI/LO, retire counter and
// a commit-trace FIFO that back-pressures the pipeline when full.
module wb_commit #(
  parameter int DEPTH    = 8,
  parameter int TRACE_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  wb_commit_if.slave  bus,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] retired,
  output logic        stall_req,
  output logic        overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 70;
  localparam logic TEN = (TRACE_EN != 0);

  logic          commit, ok, hilo_wr;
  logic          push, pop, full, do_push, drop, valid;
  logic [31:0]   hi_r, lo_r;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] entry, head;

  assign commit  = bus.wb_valid & bus.wb_adv;
  assign ok      = commit & (bus.wb_except_type == 32'd0);
  assign hilo_wr = ok & bus.wb_whilo;

  // Gating on wb_adv keeps a stalled WB instruction from writing repeatedly.
  assign rf_we    = ok & bus.wb_wreg & (bus.wb_wd != 5'd0);
  assign rf_waddr = bus.wb_wd;
  assign rf_wdata = bus.wb_wdata;

  assign hi_o = hilo_wr ? bus.wb_hi : hi_r;
  assign lo_o = hilo_wr ? bus.wb_lo : lo_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r    <= '0;
      lo_r    <= '0;
      retired <= '0;
    end else begin
      if (hilo_wr) begin
        hi_r <= bus.wb_hi;
        lo_r <= bus.wb_lo;
      end
      if (commit) retired <= retired + 32'd1;
    end
  end

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign push    = commit & TEN;
  assign pop     = valid & bus.trace_ready;
  // When full, a push only lands if the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;
  assign entry   = {bus.wb_pc, bus.wb_wd, bus.wb_wdata, rf_we};

  assign stall_req = TEN & bus.wb_valid & full & ~bus.trace_ready;

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !pop)      count <= count + CW'(1);
      else if (!do_push && pop) count <= count - CW'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  // Empty FIFO presents zeros rather than stale/uninitialised storage.
  assign head = valid ? mem[rd_ptr] : '0;

  assign bus.trace_valid = valid;
  assign bus.trace_pc    = head[69:38];
  assign bus.trace_wd    = head[37:33];
  assign bus.trace_wdata = head[32:1];
  assign bus.trace_we    = head[0];
endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: expected trace entries queue up as commits are
// issued; a monitor pops and compares on every trace transfer.
module tb_wb_commit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, hi_o, lo_o, retired;
  logic        stall_req, overflow;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_pops = 0;
  logic [69:0] exp_q[$];

  wb_commit_if bus();

  wb_commit #(.DEPTH(8), .TRACE_EN(1)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hi_o(hi_o), .lo_o(lo_o), .retired(retired),
    .stall_req(stall_req), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; checks run 2ns later.
  task automatic drive(input logic v, input logic a, input logic [31:0] pc,
                       input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                       input logic [31:0] exc, input logic rdy, input bit drop);
    logic we;
    @(negedge clk);
    bus.wb_valid = v; bus.wb_adv = a; bus.wb_pc = pc; bus.wb_wd = wd;
    bus.wb_wreg = wreg; bus.wb_wdata = wdata; bus.wb_whilo = whilo;
    bus.wb_hi = hi; bus.wb_lo = lo; bus.wb_except_type = exc; bus.trace_ready = rdy;
    we = (exc == 32'd0) && wreg && (wd != 5'd0);
    if (v && a && !drop && !rst) exp_q.push_back({pc, wd, wdata, we});
    #2;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  task automatic commit_plain(input logic [31:0] pc, input logic [4:0] wd,
                              input logic [31:0] wdata, input logic rdy, input bit drop);
    drive(1'b1, 1'b1, pc, wd, 1'b1, wdata, 1'b0, 32'd0, 32'd0, 32'd0, rdy, drop);
  endtask

  // Monitor: sample just before each rising edge, when inputs are settled.
  initial begin
    logic [69:0] got, exp;
    forever begin
      @(negedge clk);
      #4;
      if (bus.trace_valid && bus.trace_ready && !rst) begin
        got = {bus.trace_pc, bus.trace_wd, bus.trace_wdata, bus.trace_we};
        n_pops++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL trace_pop_unexpected: got %h expected no entry", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_err++;
            $display("FAIL trace_entry: got %h expected %h", got, exp);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.wb_valid = 0; bus.wb_adv = 0; bus.wb_pc = 0; bus.wb_wd = 0; bus.wb_wreg = 0;
    bus.wb_wdata = 0; bus.wb_whilo = 0; bus.wb_hi = 0; bus.wb_lo = 0;
    bus.wb_except_type = 0; bus.trace_ready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(1'b0);
    check("reset_trace_valid", 32'(bus.trace_valid), 32'd0);
    check("reset_stall_req",   32'(stall_req), 32'd0);
    check("reset_retired",     retired, 32'd0);
    check("reset_hi",          hi_o, 32'd0);
    check("reset_trace_pc",    bus.trace_pc, 32'd0);

    // Basic GPR commit.
    commit_plain(32'hBFC0_0000, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("c1_rf_we",    32'(rf_we), 32'd1);
    check("c1_rf_waddr", 32'(rf_waddr), 32'd5);
    check("c1_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
    check("c1_trace_valid_same_cycle", 32'(bus.trace_valid), 32'd0);
    idle(1'b0);
    check("c1_trace_valid", 32'(bus.trace_valid), 32'd1);
    check("c1_trace_pc",    bus.trace_pc, 32'hBFC0_0000);
    check("c1_trace_we",    32'(bus.trace_we), 32'd1);
    check("c1_retired",     retired, 32'd1);

    // HI/LO bypass, then an excepting HI/LO write that must not land.
    drive(1'b1, 1'b1, 32'hBFC0_0004, 5'd0, 1'b0, 32'd0, 1'b1, 32'h11, 32'h22, 32'd0, 1'b0, 1'b0);
    check("hilo_bypass_hi", hi_o, 32'h11);
    check("hilo_bypass_lo", lo_o, 32'h22);
    check("hilo_rf_we_wd0", 32'(rf_we), 32'd0);
    idle(1'b0);
    check("hilo_hold_hi", hi_o, 32'h11);
    check("hilo_hold_lo", lo_o, 32'h22);
    drive(1'b1, 1'b1, 32'hBFC0_0008, 5'd7, 1'b1, 32'h1234_5678, 1'b1, 32'h33, 32'h44, 32'h8, 1'b0, 1'b0);
    check("exc_hi_nobypass", hi_o, 32'h11);
    check("exc_rf_we", 32'(rf_we), 32'd0);
    idle(1'b0);
    check("exc_hi_kept", hi_o, 32'h11);
    check("exc_lo_kept", lo_o, 32'h22);
    check("exc_retired", retired, 32'd3);

    // WB held by the controller for 4 cycles, then retires once.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'hBFC0_000C, 5'd9, 1'b1, 32'hCAFE_F00D, 1'b0, 0, 0, 0, 1'b0, 1'b0);
      check("held_rf_we", 32'(rf_we), 32'd0);
    end
    drive(1'b1, 1'b1, 32'hBFC0_000C, 5'd9, 1'b1, 32'hCAFE_F00D, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    check("held_final_rf_we", 32'(rf_we), 32'd1);
    idle(1'b0);
    check("held_retired", retired, 32'd4);

    // Fill to 8 entries, then stall and a forced overflow.
    for (int i = 0; i < 4; i++)
      commit_plain(32'h100 + 32'(i * 4), 5'(i + 1), 32'h1111 * 32'(i + 1), 1'b0, 1'b0);
    idle(1'b0);
    check("full_retired", retired, 32'd8);
    check("idle_no_stall", 32'(stall_req), 32'd0);
    drive(1'b1, 1'b0, 32'h180, 5'd3, 1'b1, 32'h77, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    check("full_stall_req", 32'(stall_req), 32'd1);
    commit_plain(32'h180, 5'd3, 32'h77, 1'b0, 1'b1);
    idle(1'b0);
    check("ovf_overflow", 32'(overflow), 32'd1);
    check("ovf_head_pc",  bus.trace_pc, 32'hBFC0_0000);
    check("ovf_retired",  retired, 32'd9);

    // Full with simultaneous push and pop; count must stay at 8.
    commit_plain(32'h200, 5'd6, 32'h66, 1'b1, 1'b0);
    check("fullpp_stall_req", 32'(stall_req), 32'd0);
    drive(1'b1, 1'b0, 32'h204, 5'd6, 1'b1, 32'h66, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    check("fullpp_still_full", 32'(stall_req), 32'd1);
    check("fullpp_retired", retired, 32'd10);

    // Drain everything in order, bounded.
    for (int i = 0; i < 14; i++) begin
      idle(1'b1);
      if (!bus.trace_valid) break;
    end
    idle(1'b0);
    check("drain_empty", 32'(bus.trace_valid), 32'd0);
    check("drain_pop_count", 32'(n_pops), 32'd9);
    check("drain_queue_left", 32'(exp_q.size()), 32'd0);

    // Reset with 5 entries queued.
    drive(1'b1, 1'b1, 32'h300, 5'd2, 1'b1, 32'h3, 1'b1, 32'hAA, 32'hBB, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      commit_plain(32'h304 + 32'(i * 4), 5'd2, 32'(i), 1'b0, 1'b0);
    idle(1'b0);
    check("pre_rst_retired", retired, 32'd15);
    check("pre_rst_hi", hi_o, 32'hAA);
    @(negedge clk);
    rst = 1'b1;
    bus.wb_valid = 1'b1; bus.wb_adv = 1'b1; bus.trace_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_adv = 1'b0; bus.trace_ready = 1'b0;
    #2;
    check("rst_trace_valid", 32'(bus.trace_valid), 32'd0);
    check("rst_retired",     retired, 32'd0);
    check("rst_hi",          hi_o, 32'd0);
    check("rst_lo",          lo_o, 32'd0);
    check("rst_overflow",    32'(overflow), 32'd0);
    check("rst_stall_req",   32'(stall_req), 32'd0);

    idle(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
